// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared modes, state encoding and widths for the ALU op sequencer
// Purpose: ALU mode codes, sequencer state encoding and default widths used by
//          alu_op_sequencer, alu_cpu and the bench.
// Ports:   none (package)
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 4;
  localparam int SEQ_CNT_W  = 4;

  localparam logic [2:0] ALU_MODE_INC    = 3'b000;
  localparam logic [2:0] ALU_MODE_ADD4   = 3'b001;
  localparam logic [2:0] ALU_MODE_ADD    = 3'b010;
  localparam logic [2:0] ALU_MODE_XOROR  = 3'b011;
  localparam logic [2:0] ALU_MODE_REDOR  = 3'b100;
  localparam logic [2:0] ALU_MODE_SHL    = 3'b101;
  localparam logic [2:0] ALU_MODE_SHR    = 3'b110;
  localparam logic [2:0] ALU_MODE_MUL    = 3'b111;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_EXEC = 2'b01,
    SEQ_RESP = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_cpu.sv
// rtl/alu_cpu.sv - combinational 4-bit ALU datapath driven by the op sequencer
// Purpose: pure combinational ALU; result is 2*DATA_W wide so carries and
//          shifted-out bits land in the upper half.
// Ports:
//   a      in   DATA_W     operand A
//   b      in   DATA_W     operand B
//   mode   in   3          operation select (ALU_MODE_*)
//   result out  2*DATA_W   operation result
module alu_cpu
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          mode,
  output logic [2*DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] ax;
  logic [2*DATA_W-1:0] bx;

  assign ax = {{DATA_W{1'b0}}, a};
  assign bx = {{DATA_W{1'b0}}, b};

  always_comb begin
    result = '0;
    case (mode)
      ALU_MODE_INC:   result = ax + {{(2*DATA_W-1){1'b0}}, 1'b1};
      ALU_MODE_ADD4:  result = ax + bx;
      ALU_MODE_ADD:   result = ax + bx;
      // Upper half carries XOR, lower half carries OR.
      ALU_MODE_XOROR: result = {a ^ b, a | b};
      ALU_MODE_REDOR: result = {{(2*DATA_W-1){1'b0}}, |{a, b}};
      ALU_MODE_SHL:   result = bx << a;
      ALU_MODE_SHR:   result = bx >> a;
      ALU_MODE_MUL:   result = ax * bx;
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - self-timed command sequencer that iterates one ALU op N times
// Purpose: accepts (mode, A, count) commands, issues the ALU op once per cycle
//          with the accumulator low half fed back as B, and returns the final
//          accumulator plus a sticky overflow flag.
// Ports:
//   clock, reset               clock; asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_mode/cmd_a/cmd_count   command payload
//   cmd_clear                  zero the accumulator at acceptance
//   abort                      cancel current command (EXEC or RESP)
//   alu_a/alu_b/alu_mode       drive the external ALU
//   alu_result                 combinational ALU result
//   res_valid/res_ready        result handshake
//   res_data/res_ovf           final accumulator and sticky overflow
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_mode,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [CNT_W-1:0]    cmd_count,
  input  logic                cmd_clear,
  input  logic                abort,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_mode,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res_data,
  output logic                res_ovf
);

  seq_state_e          state;
  seq_state_e          state_next;
  logic                ready_q;
  logic [DATA_W-1:0]   a_q;
  logic [2:0]          mode_q;
  logic [CNT_W-1:0]    remaining;
  logic [2*DATA_W-1:0] acc;
  logic                ovf;
  logic                accept;
  logic                iterate;

  // ready_q keeps cmd_ready low while reset is held and for the release
  // edge itself, so nothing is accepted until the first clean IDLE cycle.
  assign cmd_ready = ready_q && (state == SEQ_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // EXEC runs one extra cycle with remaining==0 that issues no op; this is
  // what places res_valid after edge N+1 (and after edge 1 for count=0).
  assign iterate   = (state == SEQ_EXEC) && (remaining != '0) && !abort;

  assign alu_a     = a_q;
  assign alu_mode  = mode_q;
  assign alu_b     = acc[DATA_W-1:0];
  assign res_valid = (state == SEQ_RESP);
  assign res_data  = acc;
  assign res_ovf   = ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE: begin
        if (accept) state_next = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (abort)                   state_next = SEQ_IDLE;
        else if (remaining == '0)    state_next = SEQ_RESP;
      end
      SEQ_RESP: begin
        // abort wins over a simultaneous result handshake; both return to IDLE.
        if (abort || res_ready)      state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      a_q       <= '0;
      mode_q    <= '0;
      remaining <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        remaining <= cmd_count;
        ovf       <= 1'b0;
        if (cmd_clear) acc <= '0;
        // A zero-count command issues no op, so the ALU drive keeps its last value.
        if (cmd_count != '0) begin
          a_q    <= cmd_a;
          mode_q <= cmd_mode;
        end
      end
      if (iterate) begin
        acc       <= alu_result;
        ovf       <= ovf | (|alu_result[2*DATA_W-1:DATA_W]);
        remaining <= remaining - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with alu_cpu beside it
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_count;
  logic       cmd_clear;
  logic       abort;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_mode;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_cpu #(.DATA_W(4)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .mode   (alu_mode),
    .result (alu_result)
  );

  alu_op_sequencer #(.DATA_W(4), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_a      (cmd_a),
    .cmd_count  (cmd_count),
    .cmd_clear  (cmd_clear),
    .abort      (abort),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf)
  );

  typedef struct {
    logic [2:0] mode;
    logic [3:0] a;
    logic [3:0] count;
    logic       clear;
    logic [7:0] data;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives a command at a negedge, lets it be accepted on the next posedge,
  // and returns at the following negedge with cmd_valid dropped.
  task automatic send_cmd(input logic [2:0] m, input logic [3:0] a,
                          input logic [3:0] n, input logic clr);
    @(negedge clock);
    cmd_mode  = m;
    cmd_a     = a;
    cmd_count = n;
    cmd_clear = clr;
    cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", {15'd0, cmd_ready}, 16'd1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until res_valid; bounded.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    if (!res_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_resp_timeout actual=%0d expected=res_valid", lat);
    end
  endtask

  task automatic take_resp();
    res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    res_ready = 1'b0;
    chk("res_valid_after_take", {15'd0, res_valid}, 16'd0);
  endtask

  initial begin
    int lat;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 3'd0;
    cmd_a     = 4'd0;
    cmd_count = 4'd0;
    cmd_clear = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;

    //            mode    a      cnt    clr   data   ovf  lat
    vecs[0] = '{3'b001, 4'h3, 4'd4,  1'b1, 8'h0C, 1'b0, 5};
    vecs[1] = '{3'b001, 4'h3, 4'd6,  1'b1, 8'h12, 1'b1, 7};
    vecs[2] = '{3'b000, 4'h5, 4'd1,  1'b1, 8'h06, 1'b0, 2};
    vecs[3] = '{3'b101, 4'h1, 4'd2,  1'b0, 8'h18, 1'b1, 3};
    vecs[4] = '{3'b010, 4'h7, 4'd0,  1'b0, 8'h18, 1'b0, 1};
    vecs[5] = '{3'b011, 4'h5, 4'd1,  1'b1, 8'h55, 1'b1, 2};
    vecs[6] = '{3'b110, 4'h1, 4'd2,  1'b0, 8'h01, 1'b0, 3};
    vecs[7] = '{3'b100, 4'h0, 4'd1,  1'b0, 8'h01, 1'b0, 2};
    vecs[8] = '{3'b111, 4'h3, 4'd2,  1'b0, 8'h09, 1'b0, 3};
    vecs[9] = '{3'b010, 4'hF, 4'd15, 1'b1, 8'h11, 1'b1, 16};

    // Reset held for 3 cycles.
    repeat (3) begin
      @(negedge clock);
      chk("reset_cmd_ready", {15'd0, cmd_ready}, 16'd0);
      chk("reset_res_valid", {15'd0, res_valid}, 16'd0);
      chk("reset_res_data", {8'd0, res_data}, 16'h00);
    end
    chk("reset_res_ovf", {15'd0, res_ovf}, 16'd0);
    chk("reset_alu_mode", {13'd0, alu_mode}, 16'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("release_cmd_ready", {15'd0, cmd_ready}, 16'd1);

    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].mode, vecs[i].a, vecs[i].count, vecs[i].clear);
      wait_resp(lat);
      chk($sformatf("vec%0d_lat", i), lat[15:0], vecs[i].lat[15:0]);
      chk($sformatf("vec%0d_data", i), {8'd0, res_data}, {8'd0, vecs[i].data});
      chk($sformatf("vec%0d_ovf", i), {15'd0, res_ovf}, {15'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_cmd_ready_busy", i), {15'd0, cmd_ready}, 16'd0);
      if (vecs[i].count != 4'd0) begin
        chk($sformatf("vec%0d_alu_a", i), {12'd0, alu_a}, {12'd0, vecs[i].a});
        chk($sformatf("vec%0d_alu_mode", i), {13'd0, alu_mode}, {13'd0, vecs[i].mode});
      end
      take_resp();
    end

    // Backpressure: result held 4 cycles while cmd_valid is offered.
    send_cmd(3'b001, 4'h1, 4'd1, 1'b1);
    wait_resp(lat);
    chk("bp_lat", lat[15:0], 16'd2);
    repeat (4) begin
      cmd_valid = 1'b1;
      cmd_mode  = 3'b000;
      cmd_a     = 4'h9;
      cmd_count = 4'd3;
      cmd_clear = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("bp_res_valid", {15'd0, res_valid}, 16'd1);
      chk("bp_res_data", {8'd0, res_data}, 16'h01);
      chk("bp_res_ovf", {15'd0, res_ovf}, 16'd0);
      chk("bp_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    end
    cmd_valid = 1'b0;
    take_resp();
    chk("bp_idle_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    repeat (2) begin
      @(negedge clock);
      chk("bp_no_phantom", {15'd0, res_valid}, 16'd0);
    end

    // abort held during IDLE acceptance is ignored.
    abort = 1'b1;
    send_cmd(3'b000, 4'h3, 4'd1, 1'b1);
    abort = 1'b0;
    wait_resp(lat);
    chk("idle_abort_data", {8'd0, res_data}, 16'h04);
    take_resp();

    // Seed acc=1, then mul a=2 count=3: 2,4, abort before the third op.
    send_cmd(3'b000, 4'h0, 4'd1, 1'b1);
    wait_resp(lat);
    chk("seed_data", {8'd0, res_data}, 16'h01);
    take_resp();
    send_cmd(3'b111, 4'h2, 4'd3, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("abort_iter1_b", {12'd0, alu_b}, 16'h2);
    @(posedge clock);
    @(negedge clock);
    chk("abort_iter2_b", {12'd0, alu_b}, 16'h4);
    abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_res_valid", {15'd0, res_valid}, 16'd0);
    chk("abort_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("abort_acc_b", {12'd0, alu_b}, 16'h4);
    chk("abort_alu_a_held", {12'd0, alu_a}, 16'h2);
    chk("abort_alu_mode_held", {13'd0, alu_mode}, 16'd7);
    repeat (2) begin
      @(negedge clock);
      chk("abort_no_resp", {15'd0, res_valid}, 16'd0);
    end
    send_cmd(3'b000, 4'h0, 4'd0, 1'b0);
    wait_resp(lat);
    chk("abort_acc_lat", lat[15:0], 16'd1);
    chk("abort_acc_data", {8'd0, res_data}, 16'h04);
    chk("abort_acc_ovf", {15'd0, res_ovf}, 16'd0);
    take_resp();

    // Async reset in the middle of EXEC.
    send_cmd(3'b001, 4'h1, 4'd10, 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_exec_b", {12'd0, alu_b}, 16'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("async_res_valid", {15'd0, res_valid}, 16'd0);
    chk("async_res_data", {8'd0, res_data}, 16'h00);
    chk("async_alu_a", {12'd0, alu_a}, 16'h0);
    chk("async_alu_b", {12'd0, alu_b}, 16'h0);
    chk("async_alu_mode", {13'd0, alu_mode}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("async_release_ready", {15'd0, cmd_ready}, 16'd1);
    repeat (3) begin
      @(negedge clock);
      chk("async_no_resp", {15'd0, res_valid}, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
